fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
- Read-side controller for the 8x18 fifo; drains it into a downstream valid/ready stream.
- Issues read strobes (read + en) to the fifo whenever it is non-empty and there is room locally.
- Absorbs the fifo's 1-cycle registered read latency in a 2-entry output skid buffer, so it sustains 1 word/cycle when downstream is always ready.
- Sits between the fifo's fifo_out/fifo_empty pins and the consuming datapath.

Parameters:
- DATA_W, 18, width of fifo words and stream data.
- CNT_W, 16, width of the delivered-word counter (optional feature only).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- drain_en  input  1  1 = controller may issue fifo reads; 0 = no new reads are issued (in-flight and buffered words still deliver).
- fifo_empty  input  1  fifo empty flag.
- fifo_out  input  DATA_W  fifo read data; valid the cycle after a read strobe is sampled.
- fifo_read  output  1  read strobe to the fifo.
- fifo_en  output  1  enable to the fifo; identical to fifo_read.
- m_valid  output  1  stream data valid.
- m_data  output  DATA_W  stream data; head of the skid buffer.
- m_ready  input  1  downstream accepts m_data this cycle.
- word_cnt  output  CNT_W  count of words delivered (present only with the optional feature).

Behaviour:
- State:
  - occ: 0..2, buffer occupancy; encoded as FSM states EMPTY, ONE, TWO.
  - pend: 1 bit; a read was issued last cycle and its data is on fifo_out now.
  - 1-bit head and tail pointers into a 2-entry buffer.
- pop = m_valid & m_ready.
- issue (combinational) = drain_en & ~fifo_empty & ((occ + pend - pop) < 2).
  - Arithmetic is 3-bit unsigned; pop is never 1 when occ = 0.
  - fifo_read = fifo_en = issue. Never asserted while rst = 1.
- Each clock edge:
  - pend <= issue.
  - If pend: buffer[tail] <= fifo_out; tail toggles.
  - If pop: head toggles.
  - occ <= occ + pend - pop.
- Simultaneous push and pop is legal in every state:
  - EMPTY: push only.
  - ONE: push+pop keeps ONE.
  - TWO: push cannot coincide with TWO. The issue rule guarantees occ + pend <= 2 at all times.
- FSM transitions: EMPTY->ONE on push; ONE->TWO on push & ~pop; ONE->EMPTY on pop & ~push; TWO->ONE on pop. All other cases hold.
- m_valid = (occ != 0), registered state only; no combinational path from fifo_out to m_data.
- m_data = buffer[head].
- Stream rule: once m_valid = 1, m_valid and m_data stay stable until pop.
- Latency: read issued in cycle N -> word captured at end of cycle N+1 -> m_valid in cycle N+2 (buffer empty, m_ready = 1).
- Throughput: with m_ready held 1 and fifo never empty, fifo_read is high every cycle and m_valid is high every cycle after the initial 2-cycle fill.
- Backpressure: with m_ready = 0, at most 2 reads are issued, then fifo_read stays 0 until a pop.
- fifo_empty toggling: it is sampled only for issue. A word in flight (pend = 1) is always captured.
- drain_en dropped mid-burst: the pending word is still captured; buffered words still drain.
- Reset (including mid-operation): occ = 0 (EMPTY), pend = 0, pointers = 0, m_valid = 0, m_data = 0 (buffer cleared), fifo_read = fifo_en = 0, word_cnt = 0. An in-flight word is discarded.

Optional Feature:
- Macro: FIFO_RD_CNT_EN.
- Defined:
  - word_cnt port exists.
  - word_cnt increments by 1 on every pop, saturates at 2^CNT_W-1, and clears on rst.
- Undefined: word_cnt port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles with fifo_empty = 0, drain_en = 1 -> fifo_read = 0, m_valid = 0, m_data = 0, word_cnt = 0 throughout reset.
- Single word: fifo holds 18'h2A5A5, fifo_empty deasserts cycle 0, m_ready = 1 -> fifo_read high cycle 0; m_valid high cycle 2 with m_data = 18'h2A5A5; one pop; word_cnt = 1.
- Streaming: 8 words 18'h00001..18'h00008, m_ready = 1 -> fifo_read high 8 consecutive cycles; m_valid high 8 consecutive cycles; data in order; word_cnt = 8.
- Backpressure: m_ready = 0 with 8 words available -> exactly 2 read strobes; m_data holds 18'h00001 stable. Raise m_ready -> remaining 6 delivered in order, no loss or duplicate.
- drain_en/empty boundary: drop drain_en the cycle after a read -> that word still appears on m_data; no further fifo_read until drain_en = 1. Assert fifo_empty with occ = 1 -> fifo_read = 0; buffered word still delivered.
- Reset mid-operation: rst in the cycle after a read with occ = 1 -> next cycle m_valid = 0, occ EMPTY, in-flight word not delivered. Counter saturation (CNT_W = 4): 20 pops -> word_cnt = 15.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side controller for the 8x18 fifo. It strobes fifo reads whenever the
// fifo is non-empty and local space exists, and absorbs the fifo's one-cycle
// registered read latency in a 2-entry skid buffer. This lets it stream one
// word per cycle into a valid/ready consumer.
//
// Optional build macro: FIFO_RD_CNT_EN
//   Adds the word_cnt output, a saturating count of delivered words.
//
// Parameters
//   DATA_W      fifo word / stream data width
//   CNT_W       delivered-word counter width (FIFO_RD_CNT_EN only)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   drain_en    1 = new fifo reads may be issued
//   fifo_empty  fifo empty flag (sampled only to decide a new read)
//   fifo_out    fifo read data, valid the cycle after a read strobe
//   fifo_read   fifo read strobe
//   fifo_en     fifo enable, identical to fifo_read
//   m_valid     stream valid, driven from registered occupancy only
//   m_data      stream data, head of the skid buffer
//   m_ready     downstream accepts m_data this cycle
//   word_cnt    delivered-word count (FIFO_RD_CNT_EN only)
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
  parameter int DATA_W = 18,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drain_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_out,
  output logic              fifo_read,
  output logic              fifo_en,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0]  word_cnt
`endif
);

  // Buffer occupancy states
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_pend;
  logic              r_head;
  logic              r_tail;
  logic [DATA_W-1:0] r_buf [2];

  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_level;

  assign m_valid = (r_state != S_EMPTY);
  assign m_data  = r_buf[r_head];
  assign w_pop   = m_valid & m_ready;

  // Occupancy after this edge, counting the word already in flight. A new read
  // is only safe if that still leaves room for the word it will return, which
  // keeps occupancy plus in-flight at or below 2. The state encoding equals
  // the occupancy, so it is used directly as the count.
  assign w_level = {1'b0, r_state} + {2'b00, r_pend} - {2'b00, w_pop};

  assign w_issue   = ~rst & drain_en & ~fifo_empty & (w_level < 3'd2);
  assign fifo_read = w_issue;
  assign fifo_en   = w_issue;

  // A push is the capture of the in-flight word (r_pend).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (r_pend) w_state_nxt = S_ONE;
      S_ONE: begin
        if (r_pend & ~w_pop)      w_state_nxt = S_TWO;
        else if (~r_pend & w_pop) w_state_nxt = S_EMPTY;
      end
      S_TWO:   if (w_pop) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Stage boundary: the read strobe registers into r_pend; the returned word
  // is written into the skid buffer one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_EMPTY;
      r_pend   <= 1'b0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_issue;
      if (r_pend) begin
        r_buf[r_tail] <= fifo_out;
        r_tail        <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] r_word_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt <= '0;
    end else if (w_pop && (r_word_cnt != {CNT_W{1'b1}})) begin
      r_word_cnt <= r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign word_cnt = r_word_cnt;
`else
  // Keeps CNT_W referenced when the counter is not built.
  logic [CNT_W-1:0] w_cnt_unused;
  assign w_cnt_unused = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;
  localparam int DW = 18;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          drain_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_out;
  logic          fifo_read;
  logic          fifo_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
`ifdef FIFO_RD_CNT_EN
  logic [CW-1:0] word_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .drain_en(drain_en), .fifo_empty(fifo_empty),
    .fifo_out(fifo_out), .fifo_read(fifo_read), .fifo_en(fifo_en),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
`ifdef FIFO_RD_CNT_EN
    , .word_cnt(word_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural fifo feeding the DUT
  logic [DW-1:0] src[$];
  bit            force_empty;

  // Reference model: words held locally, the word in flight, delivered count
  logic [DW-1:0] rq[$];
  bit            rpend;
  logic [DW-1:0] rpend_d;
  bit            rcleared;
  int            rcnt;

  // Values seen at the last sample point, and words accepted downstream
  bit            s_read, s_valid;
  logic [DW-1:0] s_data;
  logic [DW-1:0] popped[$];

  typedef struct {
    bit            rst, drain, ready;
    bit            e_read, e_valid, e_chkd;
    logic [DW-1:0] e_data;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive_fifo();
    fifo_empty = (src.size() == 0) || force_empty;
  endtask

  // One clock cycle: inputs are already set; check at negedge, update at posedge.
  task automatic cycle(input bit tchk, input bit e_read, input bit e_valid,
                       input bit e_chkd, input logic [DW-1:0] e_data);
    bit            e_issue, e_pop, e_mv, s_empty;
    int            lvl;
    logic [DW-1:0] w;
    drive_fifo();
    @(negedge clk);
    e_mv    = (rq.size() > 0);
    e_pop   = e_mv && m_ready && !rst;
    lvl     = rq.size() + int'(rpend) - int'(e_mv && m_ready);
    e_issue = !rst && drain_en && !fifo_empty && (lvl < 2);
    chk("fifo_read", fifo_read, e_issue);
    chk("fifo_en", fifo_en, e_issue);
    chk("m_valid", m_valid, e_mv);
    if (e_mv) chk("m_data", m_data, rq[0]);
    else if (rcleared) chk("m_data_cleared", m_data, 0);
`ifdef FIFO_RD_CNT_EN
    chk("word_cnt", word_cnt, rcnt);
`endif
    if (tchk) begin
      chk("tbl_read", fifo_read, e_read);
      chk("tbl_valid", m_valid, e_valid);
      if (e_chkd) chk("tbl_data", m_data, e_data);
    end
    s_read  = fifo_read;
    s_valid = m_valid;
    s_data  = m_data;
    s_empty = fifo_empty;
    if (m_valid && m_ready && !rst) popped.push_back(m_data);
    @(posedge clk);
    w = fifo_out;
    if (s_read && !s_empty) w = src.pop_front();
    #1;
    fifo_out = w;
    if (rst) begin
      rq.delete();
      rpend    = 1'b0;
      rcleared = 1'b1;
      rcnt     = 0;
    end else begin
      if (e_pop) begin
        rq.delete(0);
        if (rcnt < (2**CW) - 1) rcnt++;
      end
      if (rpend) begin
        rq.push_back(rpend_d);
        rcleared = 1'b0;
      end
      rpend = e_issue;
      if (e_issue) rpend_d = w;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int nr, nv, fr, lr, fv, lv, nchg;

    // Reset with a word already waiting in the fifo
    rst = 1'b1; drain_en = 1'b1; m_ready = 1'b1; force_empty = 1'b0;
    fifo_out = '0;
    src.push_back(18'h2A5A5);
    drive_fifo();
    rq.delete(); rpend = 1'b0; rpend_d = '0; rcleared = 1'b1; rcnt = 0;
    @(posedge clk); #1;

    // Reset (2 cycles) then a single word: read at cycle 0, valid at cycle 2
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 18'h00000};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 18'h00000};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 18'h00000};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 18'h00000};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 18'h2A5A5};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00000};
    for (int i = 0; i < 6; i++) begin
      rst = tbl[i].rst; drain_en = tbl[i].drain; m_ready = tbl[i].ready;
      cycle(1'b1, tbl[i].e_read, tbl[i].e_valid, tbl[i].e_chkd, tbl[i].e_data);
    end

    // Streaming 8 words with m_ready held high
    for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
    popped.delete();
    nr = 0; nv = 0; fr = -1; lr = -1; fv = -1; lv = -1;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      if (s_read)  begin nr++; if (fr < 0) fr = c; lr = c; end
      if (s_valid) begin nv++; if (fv < 0) fv = c; lv = c; end
    end
    chk("stream_reads", nr, 8);
    chk("stream_read_span", lr - fr, 7);
    chk("stream_valids", nv, 8);
    chk("stream_valid_span", lv - fv, 7);
    chk("stream_latency", fv - fr, 2);
    chk("stream_count", popped.size(), 8);
    for (int i = 0; i < popped.size(); i++) chk("stream_order", popped[i], i + 1);

    // Backpressure: only two reads, head word held stable
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
    nr = 0; nchg = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      if (s_read) nr++;
      if (s_valid && s_data != 18'h00001) nchg++;
    end
    chk("bp_reads", nr, 2);
    chk("bp_valid", s_valid, 1);
    chk("bp_data", s_data, 18'h00001);
    chk("bp_stable", nchg, 0);
    m_ready = 1'b1;
    popped.delete();
    run(12);
    chk("bp_count", popped.size(), 8);
    for (int i = 0; i < popped.size(); i++) chk("bp_order", popped[i], i + 1);

    // drain_en dropped the cycle after a read
    src.push_back(18'h0000A); src.push_back(18'h0000B); src.push_back(18'h0000C);
    m_ready = 1'b0; drain_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("drain_first_read", s_read, 1);
    drain_en = 1'b0; nr = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      if (s_read) nr++;
    end
    chk("drain_off_reads", nr, 0);
    chk("drain_inflight_valid", s_valid, 1);
    chk("drain_inflight_data", s_data, 18'h0000A);
    // fifo reports empty with one word buffered
    drain_en = 1'b1; force_empty = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("empty_no_read", s_read, 0);
    m_ready = 1'b1; popped.delete();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("empty_no_read2", s_read, 0);
    force_empty = 1'b0;
    run(8);
    chk("drain_count", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("drain_w0", popped[0], 18'h0000A);
      chk("drain_w1", popped[1], 18'h0000B);
      chk("drain_w2", popped[2], 18'h0000C);
    end

    // Reset while a word is in flight and one is buffered
    m_ready = 1'b0; drain_en = 1'b1;
    src.push_back(18'h00014);
    run(2);
    src.push_back(18'h00015);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("mid_rst_read", s_read, 1);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0; m_ready = 1'b1; popped.delete();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("mid_rst_valid", s_valid, 0);
    run(4);
    chk("mid_rst_discard", popped.size(), 0);

    // Counter saturation: 20 pops into a 4-bit counter
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) src.push_back(DW'(18'h00100 + i));
    popped.delete();
    run(26);
    chk("sat_pops", popped.size(), 20);
`ifdef FIFO_RD_CNT_EN
    chk("sat_word_cnt", word_cnt, 15);
`endif

    // Randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      if (src.size() < 6 && ($urandom % 2 == 0)) src.push_back(DW'($urandom));
      drain_en    = ($urandom % 8) != 0;
      force_empty = ($urandom % 6) == 0;
      m_ready     = ($urandom % 3) != 0;
      rst         = ($urandom % 200) == 0;
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
